sipo_stream: RTL and testbench

Parametrised serial-in/parallel-out frame assembler with valid/ready handshakes on both sides. It collects `MEMORY_WID` words of `DATA_WID` bits into one flat parallel frame. A separate output holding register double-buffers the frame, so assembly of the next frame continues while the current one waits for the consumer. It is the next-generation SIPO in the datapath, sitting between any word-serial producer and a wide parallel consumer, and adds selectable lane order and optional partial-frame flush.

---
 rtl/sipo_stream.sv | 78 +++++++
 tb/tb_sipo_stream.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sipo_stream.sv
// rtl/sipo_stream.sv - word-serial to parallel frame assembler with double-buffered output
// Optional partial-frame flush on in_last is enabled by defining SIPO_FLUSH_EN.
module sipo_stream #(
  parameter int DATA_WID   = 8,
  parameter int MEMORY_WID = 4,
  parameter int ORDER      = 0,
  localparam int CNT_W     = $clog2(MEMORY_WID + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WID-1:0]            in_data,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WID*MEMORY_WID-1:0] out_data,
  output logic [CNT_W-1:0]               out_count,
  output logic [CNT_W-1:0]               fill_level
);

  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(MEMORY_WID - 1);

  logic [DATA_WID*MEMORY_WID-1:0] asm_buf;
  logic [DATA_WID*MEMORY_WID-1:0] next_frame;
  logic [CNT_W-1:0]               lane;
  logic                           completing;
  logic                           accept;

  // A word that would finish a frame may only enter once the output register can take it.
`ifdef SIPO_FLUSH_EN
  assign completing = (fill_level == LAST_POS) || in_last;
`else
  assign completing = (fill_level == LAST_POS);
  logic unused_last;
  assign unused_last = in_last;
`endif

  assign in_ready = !completing || !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign lane     = (ORDER != 0) ? (LAST_POS - fill_level) : fill_level;

  always_comb begin
    next_frame = asm_buf;
    for (int k = 0; k < MEMORY_WID; k++) begin
      if (lane == CNT_W'(k)) begin
        next_frame[k*DATA_WID +: DATA_WID] = in_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_buf    <= '0;
      fill_level <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_count  <= '0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        if (completing) begin
          out_data   <= next_frame;
          out_count  <= fill_level + 1'b1;
          out_valid  <= 1'b1;
          fill_level <= '0;
          asm_buf    <= '0;
        end else begin
          asm_buf    <= next_frame;
          fill_level <= fill_level + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sipo_stream.sv
// tb/tb_sipo_stream.sv - directed self-checking bench for sipo_stream (both lane orders)
module tb_sipo_stream;
  localparam int DW    = 8;
  localparam int MW    = 4;
  localparam int CNT_W = $clog2(MW + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;

  logic in_ready0, in_ready1, out_valid0, out_valid1;
  logic [DW*MW-1:0] out_data0, out_data1;
  logic [CNT_W-1:0] out_count0, out_count1, fill0, fill1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sipo_stream #(.DATA_WID(DW), .MEMORY_WID(MW), .ORDER(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_count(out_count0), .fill_level(fill0)
  );

  sipo_stream #(.DATA_WID(DW), .MEMORY_WID(MW), .ORDER(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_count(out_count1), .fill_level(fill1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready0); end
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid0); end
    checks++; if (out_data0 !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data0); end
    checks++; if (out_count0 !== 3'd0) begin errors++; $display("FAIL reset_out_count got %0d exp 0", out_count0); end
    checks++; if (fill0 !== 3'd0) begin errors++; $display("FAIL reset_fill got %0d exp 0", fill0); end
    checks++; if (out_data1 !== 32'h0) begin errors++; $display("FAIL reset_out_data_o1 got %h exp 0", out_data1); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [7:0] words [4];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = words[i];
      step();
    end
    in_valid = 1'b0;
    checks++; if (out_valid0 !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", out_valid0); end
    checks++; if (out_data0 !== 32'h44332211) begin errors++; $display("FAIL basic_data_o0 got %h exp 44332211", out_data0); end
    checks++; if (out_data1 !== 32'h11223344) begin errors++; $display("FAIL basic_data_o1 got %h exp 11223344", out_data1); end
    checks++; if (out_count0 !== 3'd4) begin errors++; $display("FAIL basic_count got %0d exp 4", out_count0); end
    checks++; if (fill0 !== 3'd0) begin errors++; $display("FAIL basic_fill got %0d exp 0", fill0); end
    step();
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL basic_drain got %b exp 0", out_valid0); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      step();
      if (i == 4) begin
        checks++; if (out_valid0 !== 1'b1) begin errors++; $display("FAIL bp_first_valid got %b exp 1", out_valid0); end
      end
    end
    in_data = 8'h08;
    #1;
    checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL bp_ready_low got %b exp 0", in_ready0); end
    checks++; if (fill0 !== 3'd3) begin errors++; $display("FAIL bp_fill got %0d exp 3", fill0); end
    step();
    step();
    checks++; if (fill0 !== 3'd3) begin errors++; $display("FAIL bp_fill_hold got %0d exp 3", fill0); end
    checks++; if (out_data0 !== 32'h04030201) begin errors++; $display("FAIL bp_held_data got %h exp 04030201", out_data0); end
    checks++; if (out_count0 !== 3'd4) begin errors++; $display("FAIL bp_held_count got %0d exp 4", out_count0); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL bp_ready_release got %b exp 1", in_ready0); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid0 !== 1'b1) begin errors++; $display("FAIL bp_second_valid got %b exp 1", out_valid0); end
    checks++; if (out_data0 !== 32'h08070605) begin errors++; $display("FAIL bp_second_data got %h exp 08070605", out_data0); end
    checks++; if (out_data1 !== 32'h05060708) begin errors++; $display("FAIL bp_second_data_o1 got %h exp 05060708", out_data1); end
    checks++; if (fill0 !== 3'd0) begin errors++; $display("FAIL bp_second_fill got %0d exp 0", fill0); end
    step();
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL bp_no_dup got %b exp 0", out_valid0); end
  endtask

  task automatic test_sustained();
    logic [31:0] exp_frame;
    logic        exp_valid;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h50 + i);
      #1;
      checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL sus_ready c%0d got %b exp 1", i, in_ready0); end
      step();
      exp_valid = ((i % 4) == 3);
      checks++; if (out_valid0 !== exp_valid) begin errors++; $display("FAIL sus_valid c%0d got %b exp %b", i, out_valid0, exp_valid); end
      if (exp_valid) begin
        for (int k = 0; k < 4; k++) exp_frame[k*8 +: 8] = 8'(8'h50 + i - 3 + k);
        checks++; if (out_data0 !== exp_frame) begin errors++; $display("FAIL sus_data c%0d got %h exp %h", i, out_data0, exp_frame); end
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b0;
    step();
    in_data = 8'hBB; in_last = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
`ifdef SIPO_FLUSH_EN
    checks++; if (out_valid0 !== 1'b1) begin errors++; $display("FAIL flush_valid got %b exp 1", out_valid0); end
    checks++; if (out_data0 !== 32'h0000BBAA) begin errors++; $display("FAIL flush_data_o0 got %h exp 0000bbaa", out_data0); end
    checks++; if (out_data1 !== 32'hAABB0000) begin errors++; $display("FAIL flush_data_o1 got %h exp aabb0000", out_data1); end
    checks++; if (out_count0 !== 3'd2) begin errors++; $display("FAIL flush_count got %0d exp 2", out_count0); end
    checks++; if (fill0 !== 3'd0) begin errors++; $display("FAIL flush_fill got %0d exp 0", fill0); end
`else
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL noflush_valid got %b exp 0", out_valid0); end
    checks++; if (fill0 !== 3'd2) begin errors++; $display("FAIL noflush_fill got %0d exp 2", fill0); end
`endif
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_frame();
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'hE1;
    step();
    in_data = 8'hE2;
    step();
    in_valid = 1'b0;
    checks++; if (fill0 !== 3'd2) begin errors++; $display("FAIL mid_fill_before got %0d exp 2", fill0); end
    #1 rst = 1'b1;
    #1;
    checks++; if (fill0 !== 3'd0) begin errors++; $display("FAIL mid_fill_async got %0d exp 0", fill0); end
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hC1 + i);
      step();
    end
    in_valid = 1'b0;
    checks++; if (out_valid0 !== 1'b1) begin errors++; $display("FAIL mid_valid got %b exp 1", out_valid0); end
    checks++; if (out_data0 !== 32'hC4C3C2C1) begin errors++; $display("FAIL mid_data got %h exp c4c3c2c1", out_data0); end
    checks++; if (out_data1 !== 32'hC1C2C3C4) begin errors++; $display("FAIL mid_data_o1 got %h exp c1c2c3c4", out_data1); end
    step();
  endtask

  initial begin
    #20000;
    errors++;
    $display("FAIL watchdog got timeout exp finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_sustained();
    test_flush();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
